// File: rtl/sdram_write_buffer.sv
// Ping-pong write buffer feeding the SDRAM write sequencer through a bank handshake.
// Optional idle auto-commit is compiled in when SDRAM_WBUF_TIMEOUT_EN is defined.
module sdram_write_buffer #(
  parameter int DEPTH   = 128,
  parameter int AW      = 7
`ifdef SDRAM_WBUF_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_stb,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_mask,
  input  logic        in_flush,
  output logic        in_ready,
  output logic        overflow,
  output logic [35:0] fifo_data,
  input  logic        fifo_read,
  output logic        fifo_ready,
  input  logic        fifo_activate,
  output logic [23:0] fifo_size,
  output logic        fifo_inactive
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_READY   = 2'd2,
    ST_ACTIVE  = 2'd3
  } bank_state_t;

  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  bank_state_t [1:0] r_state;
  logic [1:0][AW:0]  r_cnt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [AW:0]       r_rd_ptr;
  logic              r_act_d;
  logic              r_in_ready;
  logic              r_overflow;
  logic              r_fifo_ready;
  logic [23:0]       r_fifo_size;
  logic [35:0]       r_fifo_data;
  logic              r_fifo_inactive;
  logic [35:0]       r_mem [0:2*DEPTH-1];

  bank_state_t [1:0] w_state_nxt;
  logic [1:0][AW:0]  w_cnt_nxt;
  logic              w_wr_bank_nxt;
  logic              w_rd_bank_nxt;
  logic [AW:0]       w_rd_ptr_nxt;
  logic              w_wr_open;
  logic              w_wr_en;
  logic [AW:0]       w_fill_cnt;
  logic              w_commit;
  logic              w_tmo_hit;
  logic              w_act_rise;
  logic              w_act_fall;
  logic              w_act_now;
  logic              w_act_nxt;
  logic              w_rd_live;
  logic [AW:0]       w_rd_addr;
  logic [AW:0]       w_wr_addr;
  logic [35:0]       w_wr_word;
  logic              w_in_ready_nxt;
  logic              w_fifo_ready_nxt;
  logic [23:0]       w_fifo_size_nxt;
  logic [35:0]       w_fifo_data_nxt;
  logic              w_fifo_inactive_nxt;

`ifdef SDRAM_WBUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          w_tmo_inc;

  always_comb begin
    w_tmo_inc = (r_state[r_wr_bank] == ST_FILLING) && (r_cnt[r_wr_bank] != CNT_ZERO) && !in_stb;
    w_tmo_hit = w_tmo_inc && (r_tmo == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= {TW{1'b0}};
    end else if (w_wr_en || w_commit) begin
      r_tmo <= {TW{1'b0}};
    end else if (w_tmo_inc) begin
      r_tmo <= r_tmo + TW'(1);
    end else begin
      r_tmo <= r_tmo;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wr_bank_nxt = r_wr_bank;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_ptr_nxt  = r_rd_ptr;

    w_wr_open  = (r_state[r_wr_bank] == ST_EMPTY) || (r_state[r_wr_bank] == ST_FILLING);
    w_wr_en    = in_stb && w_wr_open;
    w_fill_cnt = r_cnt[r_wr_bank] + {{AW{1'b0}}, w_wr_en};
    w_commit   = w_wr_open && ((w_fill_cnt == CNT_FULL) ||
                 ((in_flush || w_tmo_hit) && (w_fill_cnt != CNT_ZERO)));
    w_wr_addr  = {r_wr_bank, r_cnt[r_wr_bank][AW-1:0]};
    w_wr_word  = {in_mask, in_data};

    if (w_commit) begin
      w_state_nxt[r_wr_bank] = ST_READY;
      w_cnt_nxt[r_wr_bank]   = w_fill_cnt;
      w_wr_bank_nxt          = ~r_wr_bank;
    end else if (w_wr_en) begin
      w_state_nxt[r_wr_bank] = ST_FILLING;
      w_cnt_nxt[r_wr_bank]   = w_fill_cnt;
    end else begin
      w_wr_bank_nxt = r_wr_bank;
    end

    // Fill side only touches EMPTY/FILLING banks, read side only READY/ACTIVE ones.
    w_act_rise = fifo_activate && !r_act_d;
    w_act_fall = !fifo_activate && r_act_d;
    if (w_act_rise && r_fifo_ready && (r_state[r_rd_bank] == ST_READY)) begin
      w_state_nxt[r_rd_bank] = ST_ACTIVE;
    end else if (w_act_fall && (r_state[r_rd_bank] == ST_ACTIVE)) begin
      w_state_nxt[r_rd_bank] = ST_EMPTY;
      w_cnt_nxt[r_rd_bank]   = CNT_ZERO;
      w_rd_ptr_nxt           = CNT_ZERO;
      w_rd_bank_nxt          = ~r_rd_bank;
    end else if (fifo_read && (r_state[r_rd_bank] == ST_ACTIVE) && (r_rd_ptr != r_cnt[r_rd_bank])) begin
      w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end

    w_act_now = (r_state[0] == ST_ACTIVE) || (r_state[1] == ST_ACTIVE);
    w_act_nxt = (w_state_nxt[0] == ST_ACTIVE) || (w_state_nxt[1] == ST_ACTIVE);
    w_rd_live = (w_state_nxt[w_rd_bank_nxt] == ST_READY) || (w_state_nxt[w_rd_bank_nxt] == ST_ACTIVE);
    w_rd_addr = {w_rd_bank_nxt, w_rd_ptr_nxt[AW-1:0]};

    w_in_ready_nxt      = (w_state_nxt[w_wr_bank_nxt] == ST_EMPTY) ||
                          (w_state_nxt[w_wr_bank_nxt] == ST_FILLING);
    w_fifo_ready_nxt    = (w_state_nxt[w_rd_bank_nxt] == ST_READY) && !w_act_now && !w_act_nxt;
    w_fifo_inactive_nxt = (w_state_nxt[0] == ST_EMPTY) && (w_state_nxt[1] == ST_EMPTY) && !fifo_activate;
    w_fifo_size_nxt     = w_rd_live ? {{(23-AW){1'b0}}, w_cnt_nxt[w_rd_bank_nxt]} : 24'd0;

    // Head entry may be the word being written this very cycle (single-word flush).
    if (w_rd_live && (w_rd_ptr_nxt != w_cnt_nxt[w_rd_bank_nxt])) begin
      if (w_wr_en && (w_wr_addr == w_rd_addr)) begin
        w_fifo_data_nxt = w_wr_word;
      end else begin
        w_fifo_data_nxt = r_mem[w_rd_addr];
      end
    end else begin
      w_fifo_data_nxt = r_fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state[0]      <= ST_EMPTY;
      r_state[1]      <= ST_EMPTY;
      r_cnt           <= {2{CNT_ZERO}};
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_rd_ptr        <= CNT_ZERO;
      r_act_d         <= 1'b0;
      r_in_ready      <= 1'b1;
      r_overflow      <= 1'b0;
      r_fifo_ready    <= 1'b0;
      r_fifo_size     <= 24'd0;
      r_fifo_data     <= 36'd0;
      r_fifo_inactive <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_wr_bank       <= w_wr_bank_nxt;
      r_rd_bank       <= w_rd_bank_nxt;
      r_rd_ptr        <= w_rd_ptr_nxt;
      r_act_d         <= fifo_activate;
      r_in_ready      <= w_in_ready_nxt;
      r_overflow      <= in_stb && !r_in_ready;
      r_fifo_ready    <= w_fifo_ready_nxt;
      r_fifo_size     <= w_fifo_size_nxt;
      r_fifo_data     <= w_fifo_data_nxt;
      r_fifo_inactive <= w_fifo_inactive_nxt;
    end
  end

  assign in_ready      = r_in_ready;
  assign overflow      = r_overflow;
  assign fifo_ready    = r_fifo_ready;
  assign fifo_size     = r_fifo_size;
  assign fifo_data     = r_fifo_data;
  assign fifo_inactive = r_fifo_inactive;

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Directed scoreboard bench for sdram_write_buffer (default DEPTH=128).
module tb_sdram_write_buffer;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_stb = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic [3:0]  in_mask = 4'd0;
  logic        in_flush = 1'b0;
  logic        in_ready;
  logic        overflow;
  logic [35:0] fifo_data;
  logic        fifo_read = 1'b0;
  logic        fifo_ready;
  logic        fifo_activate = 1'b0;
  logic [23:0] fifo_size;
  logic        fifo_inactive;

  int n_total = 0;
  int n_pass  = 0;
  logic [35:0] sb[$];
  logic [35:0] last_word;

  always #5 clk = ~clk;

  sdram_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_stb(in_stb), .in_data(in_data), .in_mask(in_mask),
    .in_flush(in_flush), .in_ready(in_ready), .overflow(overflow), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .fifo_ready(fifo_ready), .fifo_activate(fifo_activate),
    .fifo_size(fifo_size), .fifo_inactive(fifo_inactive)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d, input logic [3:0] m, input logic fl, input bit track);
    in_stb = 1'b1; in_data = d; in_mask = m; in_flush = fl;
    if (track) sb.push_back({m, d});
    tick();
    in_stb = 1'b0; in_flush = 1'b0;
  endtask

  // Claim the ready bank, check head, then read n+1 times (last read must be ignored).
  task automatic drain_bank(input int n);
    logic [35:0] exp;
    fifo_activate = 1'b1;
    tick();
    check("act_ready_low", fifo_ready, 1'b0);
    check("act_size", fifo_size, n);
    exp = sb.pop_front();
    last_word = exp;
    check("head", fifo_data, exp);
    for (int k = 1; k <= n + 1; k++) begin
      fifo_read = 1'b1;
      tick();
      if (k < n) begin
        exp = sb.pop_front();
        last_word = exp;
        check("read_data", fifo_data, exp);
      end else begin
        check("read_hold", fifo_data, last_word);
      end
    end
    fifo_read = 1'b0;
  endtask

  initial begin
    #23;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    check("rst_fifo_ready", fifo_ready, 1'b0);
    check("rst_fifo_size", fifo_size, 24'd0);
    check("rst_fifo_data", fifo_data, 36'd0);
    check("rst_inactive", fifo_inactive, 1'b1);
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_inactive", fifo_inactive, 1'b1);

    // Flush with nothing written
    in_flush = 1'b1; tick(); in_flush = 1'b0;
    check("empty_flush_ready", fifo_ready, 1'b0);
    check("empty_flush_inactive", fifo_inactive, 1'b1);
    check("empty_flush_size", fifo_size, 24'd0);

    // Full-bank commit
    for (int i = 0; i < DEPTH; i++) begin
      write_word(32'(i), 4'h0, 1'b0, 1'b1);
      if (i == DEPTH - 2) check("pre_full_ready", fifo_ready, 1'b0);
      if (i == 0) check("partial_inactive", fifo_inactive, 1'b0);
    end
    check("full_ready", fifo_ready, 1'b1);
    check("full_size", fifo_size, 24'd128);
    check("full_head", fifo_data, 36'h0_00000000);
    drain_bank(DEPTH);
    fifo_activate = 1'b0; tick(); tick();
    check("rel_inactive", fifo_inactive, 1'b1);
    check("rel_size", fifo_size, 24'd0);
    check("rel_in_ready", in_ready, 1'b1);

    // Flush of a partial bank, then stb+flush in the same cycle
    for (int i = 0; i < 5; i++) write_word(32'hA5A5_0000 + 32'(i), 4'hC, 1'b0, 1'b1);
    check("pre_flush_ready", fifo_ready, 1'b0);
    in_flush = 1'b1; tick(); in_flush = 1'b0;
    check("flush_ready", fifo_ready, 1'b1);
    check("flush_size", fifo_size, 24'd5);
    check("flush_mask", fifo_data[35:32], 4'hC);
    drain_bank(5);
    fifo_activate = 1'b0; tick(); tick();
    write_word(32'h1111_2222, 4'h3, 1'b0, 1'b1);
    write_word(32'h3333_4444, 4'h5, 1'b1, 1'b1);
    check("stbflush_size", fifo_size, 24'd2);
    drain_bank(2);
    fifo_activate = 1'b0; tick(); tick();
    check("stbflush_inactive", fifo_inactive, 1'b1);

    // Both banks full, overflow, release one
    for (int i = 0; i < 2 * DEPTH; i++) begin
      write_word(32'(i), 4'(i), 1'b0, 1'b1);
      if (i == 2 * DEPTH - 2) check("ovf_pre_in_ready", in_ready, 1'b1);
    end
    check("ovf_in_ready", in_ready, 1'b0);
    write_word(32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    check("ovf_pulse", overflow, 1'b1);
    tick();
    check("ovf_pulse_end", overflow, 1'b0);
    drain_bank(DEPTH);
    fifo_activate = 1'b0; tick();
    check("ovf_rel_in_ready", in_ready, 1'b1);
    check("ovf_rel_ready_lag", fifo_ready, 1'b0);
    tick();
    check("ovf_b1_ready", fifo_ready, 1'b1);
    check("ovf_b1_size", fifo_size, 24'd128);
    check("ovf_b1_head", fifo_data, {4'h0, 32'd128});
    drain_bank(DEPTH);
    fifo_activate = 1'b0; tick(); tick();
    check("ovf_inactive", fifo_inactive, 1'b1);

    // Idle partial bank
    for (int i = 0; i < 3; i++) write_word(32'h7700_0000 + 32'(i), 4'h6, 1'b0, 1'b1);
`ifdef SDRAM_WBUF_TIMEOUT_EN
    repeat (63) tick();
    check("tmo_not_yet", fifo_ready, 1'b0);
    tick();
    check("tmo_ready", fifo_ready, 1'b1);
`else
    repeat (100) tick();
    check("no_tmo_ready", fifo_ready, 1'b0);
    in_flush = 1'b1; tick(); in_flush = 1'b0;
    check("no_tmo_flush_ready", fifo_ready, 1'b1);
`endif
    check("tmo_size", fifo_size, 24'd3);
    drain_bank(3);
    fifo_activate = 1'b0; tick(); tick();

    // Release of one bank in the same cycle the other fills up
    for (int i = 0; i < DEPTH; i++) write_word(32'h9000_0000 + 32'(i), 4'h1, 1'b0, 1'b0);
    check("sim_a_ready", fifo_ready, 1'b1);
    fifo_activate = 1'b1; tick();
    check("sim_a_active", fifo_ready, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) write_word(32'h5000_0000 + 32'(i), 4'h2, 1'b0, 1'b1);
    fifo_activate = 1'b0;
    write_word(32'h5000_0000 + 32'(DEPTH - 1), 4'h2, 1'b0, 1'b1);
    check("sim_in_ready", in_ready, 1'b1);
    check("sim_ready_lag", fifo_ready, 1'b0);
    tick();
    check("sim_b_ready", fifo_ready, 1'b1);
    check("sim_b_size", fifo_size, 24'd128);
    check("sim_b_head", fifo_data, sb[0]);

    // Asynchronous reset in the middle of a drain
    fifo_activate = 1'b1; tick();
    last_word = sb.pop_front();
    check("mid_head", fifo_data, last_word);
    for (int k = 0; k < 3; k++) begin
      fifo_read = 1'b1; tick();
      last_word = sb.pop_front();
      check("mid_read", fifo_data, last_word);
    end
    rst = 1'b0;
    #2;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_overflow", overflow, 1'b0);
    check("arst_fifo_ready", fifo_ready, 1'b0);
    check("arst_fifo_size", fifo_size, 24'd0);
    check("arst_fifo_data", fifo_data, 36'd0);
    check("arst_inactive", fifo_inactive, 1'b1);
    sb.delete();
    fifo_read = 1'b0; fifo_activate = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("after_arst_inactive", fifo_inactive, 1'b1);
    check("after_arst_in_ready", in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
